// File: rtl/johnson_phase_decoder_if.sv
// Bundles the Johnson code input, the error-clear control and every status output
// of johnson_phase_decoder; clk and rst_n stay plain ports on the module.
interface johnson_phase_decoder_if #(
    parameter int ERR_W = 8
);
    logic [3:0]       i_cnt;
    logic             i_clr_err;
    logic [2:0]       o_phase;
    logic [7:0]       o_onehot;
    logic             o_wrap;
    logic             o_illegal;
    logic             o_locked;
    logic             o_err_sticky;
    logic [ERR_W-1:0] o_err_cnt;

    modport master (
        output i_cnt, i_clr_err,
        input  o_phase, o_onehot, o_wrap, o_illegal, o_locked, o_err_sticky, o_err_cnt
    );

    modport slave (
        input  i_cnt, i_clr_err,
        output o_phase, o_onehot, o_wrap, o_illegal, o_locked, o_err_sticky, o_err_cnt
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes a 4-bit Johnson code to phase index and one-hot strobe, checks each code
// and each transition, tracks lock, and keeps a saturating count of errors seen while locked.
module johnson_phase_decoder #(
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    johnson_phase_decoder_if.slave  bus
);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    // Returns {legal, phase}; illegal codes return phase 0.
    function automatic logic [3:0] decode(input logic [3:0] c);
        case (c)
            4'b0000: decode = {1'b1, 3'd0};
            4'b1000: decode = {1'b1, 3'd1};
            4'b1100: decode = {1'b1, 3'd2};
            4'b1110: decode = {1'b1, 3'd3};
            4'b1111: decode = {1'b1, 3'd4};
            4'b0111: decode = {1'b1, 3'd5};
            4'b0011: decode = {1'b1, 3'd6};
            4'b0001: decode = {1'b1, 3'd7};
            default: decode = {1'b0, 3'd0};
        endcase
    endfunction

    function automatic logic [3:0] succ(input logic [3:0] c);
        succ = {~c[0], c[3:1]};
    endfunction

    logic [3:0]       prev_q;
    logic             prev_vld_q;
    lock_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [2:0]       phase_q;
    logic [7:0]       onehot_q;
    logic             wrap_q, illegal_q;
    logic [ERR_W-1:0] err_q, err_d, err_base;
    logic             sticky_q, sticky_d;

    logic [3:0] cur_dec, prev_dec;
    logic       cur_legal, prev_legal;
    logic       good, bad, count_err, wrap_d;

    assign cur_dec    = decode(bus.i_cnt);
    assign prev_dec   = decode(prev_q);
    assign cur_legal  = cur_dec[3];
    assign prev_legal = prev_dec[3];

    assign good    = prev_vld_q && cur_legal && prev_legal && (bus.i_cnt == succ(prev_q));
    assign bad     = prev_vld_q && !good;
    assign wrap_d  = good && (prev_q == 4'b0001);
    assign run_inc = run_q + RUN_W'(1);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        count_err = 1'b0;
        case (state_q)
            UNLOCKED: begin
                if (good) begin
                    run_d   = RUN_W'(1);
                    state_d = (LOCK_CNT == 1) ? LOCKED : LOCKING;
                end
            end
            LOCKING: begin
                if (good) begin
                    run_d = run_inc;
                    if (run_inc == RUN_W'(LOCK_CNT)) state_d = LOCKED;
                end else if (bad) begin
                    run_d   = '0;
                    state_d = UNLOCKED;
                end
            end
            LOCKED: begin
                if (bad) begin
                    run_d     = '0;
                    state_d   = UNLOCKED;
                    count_err = 1'b1;
                end
            end
            default: begin
                run_d   = '0;
                state_d = UNLOCKED;
            end
        endcase
    end

    // Clear is applied before a coincident error so that error still counts.
    always_comb begin
        err_base = bus.i_clr_err ? '0 : err_q;
        err_d    = err_base;
        sticky_d = bus.i_clr_err ? 1'b0 : sticky_q;
        if (count_err) begin
            sticky_d = 1'b1;
            if (err_base != {ERR_W{1'b1}}) err_d = err_base + ERR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            state_q    <= UNLOCKED;
            run_q      <= '0;
            phase_q    <= '0;
            onehot_q   <= '0;
            wrap_q     <= 1'b0;
            illegal_q  <= 1'b0;
            err_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            prev_q     <= bus.i_cnt;
            prev_vld_q <= 1'b1;
            state_q    <= state_d;
            run_q      <= run_d;
            wrap_q     <= wrap_d;
            illegal_q  <= !cur_legal;
            err_q      <= err_d;
            sticky_q   <= sticky_d;
            if (cur_legal) begin
                phase_q  <= cur_dec[2:0];
                onehot_q <= 8'd1 << cur_dec[2:0];
            end else begin
                onehot_q <= '0;
            end
        end
    end

    assign bus.o_phase      = phase_q;
    assign bus.o_onehot     = onehot_q;
    assign bus.o_wrap       = wrap_q;
    assign bus.o_illegal    = illegal_q;
    assign bus.o_locked     = (state_q == LOCKED);
    assign bus.o_err_sticky = sticky_q;
    assign bus.o_err_cnt    = err_q;
endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench: dut_a uses LOCK_CNT=8/ERR_W=8, dut_b uses LOCK_CNT=8/ERR_W=2 for saturation;
// both see identical stimulus.
module tb_johnson_phase_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    johnson_phase_decoder_if #(.ERR_W(8)) bus_a ();
    johnson_phase_decoder_if #(.ERR_W(2)) bus_b ();

    johnson_phase_decoder #(.LOCK_CNT(8), .ERR_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    johnson_phase_decoder #(.LOCK_CNT(8), .ERR_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [3:0] seq [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one sample into both DUTs and land 1 time unit after the sampling edge.
    task automatic step(input logic [3:0] code, input logic clr = 1'b0);
        bus_a.i_cnt     = code;
        bus_b.i_cnt     = code;
        bus_a.i_clr_err = clr;
        bus_b.i_clr_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input int phase, input logic [7:0] onehot,
                            input logic illegal, input logic wrap, input logic locked,
                            input logic sticky, input int err);
        check({tag, ".phase"},   32'(bus_a.o_phase),      32'(phase));
        check({tag, ".onehot"},  32'(bus_a.o_onehot),     32'(onehot));
        check({tag, ".illegal"}, 32'(bus_a.o_illegal),    32'(illegal));
        check({tag, ".wrap"},    32'(bus_a.o_wrap),       32'(wrap));
        check({tag, ".locked"},  32'(bus_a.o_locked),     32'(locked));
        check({tag, ".sticky"},  32'(bus_a.o_err_sticky), 32'(sticky));
        check({tag, ".err"},     32'(bus_a.o_err_cnt),    32'(err));
    endtask

    initial begin
        bus_a.i_cnt = 4'b0000; bus_b.i_cnt = 4'b0000;
        bus_a.i_clr_err = 1'b0; bus_b.i_clr_err = 1'b0;

        // Reset state
        #12;
        expect_a("reset", 0, 8'h00, 0, 0, 0, 0, 0);
        check("reset.b_err", 32'(bus_b.o_err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-run lock-in: locked after the 9th sample, wrap only on a judged 0001->0000
        for (int i = 0; i < 16; i++) begin
            step(seq[i % 8]);
            expect_a($sformatf("run%0d", i), i % 8, 8'h01 << (i % 8), 0,
                     (i == 8), (i >= 8), 0, 0);
        end

        // Illegal 0101 while locked: counted once, phase held at 7
        step(4'b0101);
        expect_a("illegal", 7, 8'h00, 1, 0, 0, 1, 1);
        step(seq[0]);
        expect_a("after_illegal", 0, 8'h01, 0, 0, 0, 1, 1);
        for (int j = 1; j <= 8; j++) begin
            step(seq[j % 8]);
            expect_a($sformatf("relock%0d", j), j % 8, 8'h01 << (j % 8), 0,
                     (j == 8), (j == 8), 1, 1);
        end

        // Held code while locked
        step(4'b1000);
        step(4'b1100);
        expect_a("pre_hold", 2, 8'h04, 0, 0, 1, 1, 1);
        step(4'b1100);
        expect_a("hold", 2, 8'h04, 0, 0, 0, 1, 2);

        // Clear alone (good transition, but not locked, so nothing counted)
        step(4'b1110, 1'b1);
        expect_a("clr_alone", 3, 8'h08, 0, 0, 0, 0, 0);
        check("clr_alone.b_err", 32'(bus_b.o_err_cnt), 0);

        // Saturation: five lock-then-hold episodes, then one with a coincident clear
        for (int e = 1; e <= 6; e++) begin
            for (int k = 0; k <= 8; k++) step(seq[k % 8]);
            check($sformatf("ep%0d.locked", e), 32'(bus_a.o_locked), 1);
            step(4'b0000, (e == 6));
            check($sformatf("ep%0d.a_err", e), 32'(bus_a.o_err_cnt), (e == 6) ? 1 : e);
            check($sformatf("ep%0d.b_err", e), 32'(bus_b.o_err_cnt),
                  (e == 6) ? 1 : ((e > 3) ? 3 : e));
            check($sformatf("ep%0d.sticky", e), 32'(bus_a.o_err_sticky), 1);
            check($sformatf("ep%0d.unlocked", e), 32'(bus_a.o_locked), 0);
        end

        // Reach LOCKED with err_cnt=2, then assert reset between edges
        for (int k = 0; k <= 8; k++) step(seq[k % 8]);
        step(4'b0000);
        check("pre_rst.err", 32'(bus_a.o_err_cnt), 2);
        for (int k = 0; k <= 8; k++) step(seq[k % 8]);
        check("pre_rst.locked", 32'(bus_a.o_locked), 1);
        check("pre_rst.err2", 32'(bus_a.o_err_cnt), 2);
        #3;
        rst_n = 1'b0;
        #1;
        expect_a("async_rst", 0, 8'h00, 0, 0, 0, 0, 0);
        check("async_rst.b_err", 32'(bus_b.o_err_cnt), 0);
        #2;
        rst_n = 1'b1;
        step(4'b0111);
        expect_a("first_after_rst", 5, 8'h20, 0, 0, 0, 0, 0);
        step(4'b0000);
        expect_a("second_after_rst", 0, 8'h01, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
